// File: rtl/crash_course_cpu_alu_seq.sv
// Sequential ALU: single-cycle ops issue a result one cycle after acceptance,
// MUL runs an iterative shift-add over DATA_WIDTH steps in a MUL_BUSY state.
module crash_course_cpu_alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic                  clk_en,
  input  logic                  system_enabled,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] input_b,
  input  logic [DATA_WIDTH-1:0] input_c,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [DATA_WIDTH-1:0] immediate,
  output logic [DATA_WIDTH-1:0] output_a,
  output logic                  result_valid,
  output logic [3:0]            flag_register
);
  localparam int W   = DATA_WIDTH;
  localparam int MSB = DATA_WIDTH - 1;
  localparam int CW  = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  // flag kinds: keep, logic (Z/N, C=V=0), arithmetic (Z/N/C/V), shift (Z/N/C)
  typedef enum logic [1:0] {FK_KEEP, FK_LOGIC, FK_ARITH, FK_SHR} fkind_t;

  state_t            state, state_nxt;
  logic              adv, accept, is_mul, mul_done;
  logic [CW-1:0]     cnt;
  logic [2*W-1:0]    acc, acc_step;
  logic [W:0]        mul_sum;
  logic [W-1:0]      mul_b, mul_c;
  logic [W-1:0]      alu_res;
  logic [W:0]        alu_sum;
  logic              alu_c, alu_v;
  fkind_t            fkind;
  logic [3:0]        alu_flags;

  assign adv      = clk_en && system_enabled;
  assign op_ready = (state == IDLE);
  assign accept   = adv && op_valid && op_ready;
  assign is_mul   = MUL_ENABLE && (opcode == 4'hC);
  assign mul_done = (cnt == CW'(1));

  // one shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole accumulator right
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (mul_c[0] ? {1'b0, mul_b} : '0);
  assign acc_step = {mul_sum, acc[W-1:1]};

  // state register
  always_ff @(posedge clk) begin
    if (sync_rst)  state <= IDLE;
    else if (adv)  state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (op_valid && is_mul) state_nxt = MUL_BUSY;
      MUL_BUSY: if (mul_done)           state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // single-cycle ALU result and flag computation
  always_comb begin
    alu_res = '0;
    alu_sum = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    fkind   = FK_KEEP;
    case (opcode)
      4'h1: begin
        alu_sum = {1'b0, input_b} + {1'b0, input_c};
        alu_res = alu_sum[W-1:0];
        alu_c   = alu_sum[W];
        alu_v   = (input_b[MSB] == input_c[MSB]) && (alu_res[MSB] != input_b[MSB]);
        fkind   = FK_ARITH;
      end
      4'h2: begin
        alu_sum = {1'b0, input_b} - {1'b0, input_c};
        alu_res = alu_sum[W-1:0];
        alu_c   = alu_sum[W];
        alu_v   = (input_b[MSB] != input_c[MSB]) && (alu_res[MSB] != input_b[MSB]);
        fkind   = FK_ARITH;
      end
      4'h3: begin alu_res = input_b & input_c; fkind = FK_LOGIC; end
      4'h4: begin alu_res = input_b | input_c; fkind = FK_LOGIC; end
      4'h5: begin alu_res = input_b ^ input_c; fkind = FK_LOGIC; end
      4'h6: begin alu_res = ~input_c;          fkind = FK_LOGIC; end
      4'h7: begin
        alu_res = {1'b0, input_c[W-1:1]};
        alu_c   = input_c[0];
        fkind   = FK_SHR;
      end
      4'h8: begin alu_res = load_data; fkind = FK_LOGIC; end
      4'hA: alu_res = immediate;
      4'hB: begin
        // carry-in is the flag registered before this operation
        alu_sum = {1'b0, input_b} + {1'b0, input_c} + {{W{1'b0}}, flag_register[0]};
        alu_res = alu_sum[W-1:0];
        alu_c   = alu_sum[W];
        alu_v   = (input_b[MSB] == input_c[MSB]) && (alu_res[MSB] != input_b[MSB]);
        fkind   = FK_ARITH;
      end
      default: alu_res = '0; // NOP/STORE/HALT/JUMP/BRANCH, and MUL when disabled
    endcase
    case (fkind)
      FK_KEEP: alu_flags = flag_register;
      default: alu_flags = {alu_v, alu_res[MSB], (alu_res == '0), alu_c};
    endcase
  end

  // datapath: result/flag registers and multiply accumulator, frozen when !adv
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      output_a      <= '0;
      result_valid  <= 1'b0;
      flag_register <= 4'b0000;
      cnt           <= '0;
      acc           <= '0;
      mul_b         <= '0;
      mul_c         <= '0;
    end else if (!adv) begin
      result_valid  <= 1'b0;
    end else begin
      result_valid  <= 1'b0;
      if (state == IDLE) begin
        if (accept && is_mul) begin
          mul_b <= input_b;
          mul_c <= input_c;
          acc   <= '0;
          cnt   <= CW'(DATA_WIDTH);
        end else if (accept) begin
          output_a      <= alu_res;
          flag_register <= alu_flags;
          result_valid  <= 1'b1;
        end
      end else begin
        acc   <= acc_step;
        mul_c <= mul_c >> 1;
        cnt   <= cnt - CW'(1);
        if (mul_done) begin
          output_a      <= acc_step[W-1:0];
          flag_register <= {(acc_step[2*W-1:W] != '0), acc_step[MSB],
                            (acc_step[W-1:0] == '0), (acc_step[2*W-1:W] != '0)};
          result_valid  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/crash_course_cpu_alu_seq.md
CRASH_COURSE_CPU_ALU_SEQ -- requirements
Module: crash_course_cpu_alu_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the operand/result width, legal range 4..32.
REQ-002 SHALL have parameter MUL_ENABLE, default 1, meaning opcode 4'hC runs the iterative multiply when 1 and is treated as NOP when 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port sync_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port clk_en, input, 1, global clock enable; no state changes while low (except reset).
REQ-006 SHALL have port system_enabled, input, 1, run enable; no state changes while low (except reset).
REQ-007 SHALL have port op_valid, input, 1, an operation is presented.
REQ-008 SHALL have port op_ready, output, 1, the block accepts an operation this cycle.
REQ-009 SHALL have port opcode, input, 4, the operation selector.
REQ-010 SHALL have ports input_b, input_c, load_data and immediate, each input, DATA_WIDTH, the operands.
REQ-011 SHALL have port output_a, output, DATA_WIDTH, the registered result.
REQ-012 SHALL have port result_valid, output, 1, a one-cycle pulse marking output_a valid.
REQ-013 SHALL have port flag_register, output, 4, {overflow, negative, zero, carry}, bits [3:0].

Function
REQ-014 SHALL define the advance condition adv = clk_en && system_enabled.
REQ-015 SHALL accept an operation on a cycle where adv && op_valid && op_ready.
REQ-016 SHALL implement a state machine with states IDLE and MUL_BUSY.
REQ-017 SHALL assert op_ready only in IDLE.
REQ-018 SHALL, for a single-cycle opcode accepted in IDLE, register output_a and the flags, pulse result_valid on the next cycle, and remain in IDLE (latency 1, throughput 1/cycle).
REQ-019 SHALL decode opcodes as: 0 NOP, 1 ADD b+c, 2 SUB b-c, 3 AND, 4 OR, 5 XOR, 6 NOT c, 7 SHR1 c, 8 LOAD (load_data), 9 STORE, A LDI (immediate), B ADC b+c+carry_flag, C MUL, D HALT, E JUMP, F BRANCH.
REQ-020 SHALL, for opcodes 0, 9, D, E and F, drive output_a to 0, still pulse result_valid, and leave all flags unchanged.
REQ-021 SHALL, for opcode A, drive output_a to immediate and leave all flags unchanged.
REQ-022 SHALL compute ADD, SUB and ADC at DATA_WIDTH+1 bits, with carry = bit DATA_WIDTH (for SUB this is the borrow, set when b<c).
REQ-023 SHALL compute overflow for ADD/ADC as (b[msb]==c[msb]) && (res[msb]!=b[msb]).
REQ-024 SHALL compute overflow for SUB as (b[msb]!=c[msb]) && (res[msb]!=b[msb]).
REQ-025 SHALL, for SHR1, set carry = c[0] and shift in 0 at the msb.
REQ-026 SHALL, for AND, OR, XOR, NOT and LOAD, update zero and negative, clear carry and clear overflow.
REQ-027 SHALL, for every flag-updating op, set zero = (result==0) and negative = result[msb].
REQ-028 SHALL, on acceptance of MUL (MUL_ENABLE=1), latch b and c, clear the accumulator, load a counter with DATA_WIDTH, and enter MUL_BUSY.
REQ-029 SHALL, on each adv cycle in MUL_BUSY, perform one shift-add step (a 2*DATA_WIDTH-bit accumulator plus 1 multiplier bit) and decrement the counter.
REQ-030 SHALL, when the counter reaches 0, present the low half on output_a, pulse result_valid, and return to IDLE, giving result_valid exactly DATA_WIDTH+1 adv cycles after acceptance.
REQ-031 SHALL, on MUL completion, set carry = overflow = (high half != 0) and set zero/negative from the low half.
REQ-032 SHALL freeze all state (counter, accumulator, state, flags) while adv is low; result_valid SHALL NOT assert on a cycle where adv was low.
REQ-033 SHALL hold output_a between results and deassert result_valid when no result is issued.
REQ-034 SHALL ignore op_valid while in MUL_BUSY; no operation is queued.
REQ-035 SHALL have ADC read the flag value registered before the current operation.

Reset
REQ-036 SHALL, on a cycle with sync_rst high, regardless of clk_en and system_enabled, set state to IDLE, output_a to 0, result_valid to 0, flag_register to 4'b0000, and clear the counter and accumulator.
REQ-037 SHALL, on sync_rst during MUL_BUSY, abort the multiply with no result_valid pulse, and assert op_ready on the cycle after reset deasserts.

Verification
REQ-038 SHALL verify (DATA_WIDTH=8) ADD b=0xFF, c=0x01 -> next cycle output_a=0x00, result_valid=1, flags=4'b0011; then ADC b=0x00, c=0x00 -> output_a=0x01, flags=4'b0000.
REQ-039 SHALL verify SUB b=0x80, c=0x01 -> output_a=0x7F, flags=4'b1000; SUB b=0x01, c=0x02 -> output_a=0xFF, flags=4'b0101.
REQ-040 SHALL verify MUL b=0x10, c=0x10 -> op_ready low for 8 cycles, result_valid on adv cycle 9, output_a=0x00, flags=4'b1011.
REQ-041 SHALL verify MUL b=7, c=6 with system_enabled low for 3 cycles mid-run -> result 0x2A delivered exactly 3 cycles late, flags=4'b0000.
REQ-042 SHALL verify sync_rst asserted at MUL cycle 4 -> no result_valid, flags=0, op_ready=1 after release, and a following ADD 2+3 returns 0x05.
REQ-043 SHALL verify back-to-back LDI 0x00, XOR 0x0F^0x0F, NOT c=0x00 on consecutive cycles -> three result_valid pulses with 0x00/0x00/0xFF; zero flag unchanged by LDI, set by XOR, and flags=4'b0100 after NOT.
